// File: rtl/spatz_vrf_read_sequencer.sv
// Streams one vector operand out of a banked VRF read port into a small
// registered FIFO, presenting elements downstream with a last-element tag.
module spatz_vrf_read_sequencer #(
  parameter  int unsigned NR_REGS        = 32,
  parameter  int unsigned ELEMS_PER_REG  = 4,
  parameter  int unsigned ELEM_WIDTH     = 64,
  parameter  int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned VADDR_WIDTH    = $clog2(NR_REGS * ELEMS_PER_REG),
  localparam int unsigned LEN_WIDTH      = VADDR_WIDTH + 1,
  localparam int unsigned REG_WIDTH      = $clog2(NR_REGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [REG_WIDTH-1:0]   req_vs_i,
  input  logic [LEN_WIDTH-1:0]   req_len_i,
  output logic [VADDR_WIDTH-1:0] vrf_raddr_o,
  output logic                   vrf_re_o,
  input  logic                   vrf_rvalid_i,
  input  logic [ELEM_WIDTH-1:0]  vrf_rdata_i,
  output logic                   op_valid_o,
  input  logic                   op_ready_i,
  output logic [ELEM_WIDTH-1:0]  op_data_o,
  output logic                   op_last_o,
  output logic                   busy_o
);

  localparam int unsigned ELEM_IDX_WIDTH = $clog2(ELEMS_PER_REG);
  localparam int unsigned PTR_WIDTH      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_WIDTH      = PTR_WIDTH + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [VADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [ELEM_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [ELEM_WIDTH-1:0]  fifo_data_d [FIFO_DEPTH];
  logic                   fifo_last_q [FIFO_DEPTH];
  logic                   fifo_last_d [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop, head_last;

  // Fullness uses the current count only; a same-cycle pop never enables a push.
  assign fifo_full  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  assign fifo_empty = (count_q == CNT_WIDTH'(0));
  assign head_last  = fifo_last_q[rd_ptr_q];

  assign vrf_re_o    = (state_q == READ) && !fifo_full;
  assign vrf_raddr_o = addr_q;
  assign push        = vrf_re_o && vrf_rvalid_i;
  assign pop         = op_valid_o && op_ready_i;

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign op_valid_o  = !fifo_empty;
  assign op_data_o   = fifo_data_q[rd_ptr_q];
  assign op_last_o   = op_valid_o && head_last;

  // Request sequencing: address walk and remaining-element count.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && (req_len_i != LEN_WIDTH'(0))) begin
          addr_d  = VADDR_WIDTH'({req_vs_i, ELEM_IDX_WIDTH'(0)});
          rem_d   = req_len_i;
          state_d = READ;
        end
      end
      READ: begin
        if (push) begin
          addr_d = addr_q + VADDR_WIDTH'(1);
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer bookkeeping.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = vrf_rdata_i;
      fifo_last_d[wr_ptr_q] = (rem_q == LEN_WIDTH'(1));
      wr_ptr_d              = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_data_q <= '{default: '0};
      fifo_last_q <= '{default: 1'b0};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
    end
  end

endmodule

// File: tb/tb_spatz_vrf_read_sequencer.sv
// Directed bench for spatz_vrf_read_sequencer: cycle-exact latency, backpressure,
// read stalls, address wrap, zero-length requests and mid-request reset.
module tb_spatz_vrf_read_sequencer;

  localparam int unsigned NADDR = 128;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  req_vs_i;
  logic [7:0]  req_len_i;
  logic [6:0]  vrf_raddr_o;
  logic        vrf_re_o;
  logic        vrf_rvalid_i;
  logic [63:0] vrf_rdata_i;
  logic        op_valid_o;
  logic        op_ready_i;
  logic [63:0] op_data_o;
  logic        op_last_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  logic [63:0] out_data_q [$];
  logic        out_last_q [$];
  int          rd_addr_q  [$];

  spatz_vrf_read_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_vs_i     (req_vs_i),
    .req_len_i    (req_len_i),
    .vrf_raddr_o  (vrf_raddr_o),
    .vrf_re_o     (vrf_re_o),
    .vrf_rvalid_i (vrf_rvalid_i),
    .vrf_rdata_i  (vrf_rdata_i),
    .op_valid_o   (op_valid_o),
    .op_ready_i   (op_ready_i),
    .op_data_o    (op_data_o),
    .op_last_o    (op_last_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // VRF contents: a distinct word per element address.
  function automatic logic [63:0] elem(input int a);
    return {32'hC0DE_0000 + 32'(a), ~32'(a)};
  endfunction

  assign vrf_rdata_i = elem(int'(vrf_raddr_o));

  // Record delivered elements and issued reads mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (op_valid_o && op_ready_i) begin
        out_data_q.push_back(op_data_o);
        out_last_q.push_back(op_last_o);
      end
      if (vrf_re_o && vrf_rvalid_i) rd_addr_q.push_back(int'(vrf_raddr_o));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    out_data_q.delete();
    out_last_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic send_req(input int vs, input int len);
    req_valid_i = 1'b1;
    req_vs_i    = 5'(vs);
    req_len_i   = 8'(len);
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      step();
      n++;
    end
    if (busy_o) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_stream(input string tag, input int base, input int len);
    chk({tag, "_nout"}, 64'(out_data_q.size()), 64'(len));
    chk({tag, "_nrd"}, 64'(rd_addr_q.size()), 64'(len));
    for (int i = 0; i < len && i < out_data_q.size(); i++) begin
      chk({tag, "_data"}, out_data_q[i], elem((base + i) % NADDR));
      chk({tag, "_last"}, 64'(out_last_q[i]), 64'(i == len - 1));
    end
    for (int i = 0; i < len && i < rd_addr_q.size(); i++) begin
      chk({tag, "_raddr"}, 64'(rd_addr_q[i]), 64'((base + i) % NADDR));
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_vs_i     = '0;
    req_len_i    = '0;
    vrf_rvalid_i = 1'b1;
    op_ready_i   = 1'b1;
    step();
    step();
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_re", 64'(vrf_re_o), 64'd0);
    chk("rst_valid", 64'(op_valid_o), 64'd0);
    chk("rst_last", 64'(op_last_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_raddr", 64'(vrf_raddr_o), 64'd0);
    chk("rst_data", op_data_o, 64'd0);
    rst_i = 1'b0;
    step();

    // vs=2 len=4: cycle-exact latency and throughput
    clear_logs();
    send_req(2, 4);
    for (int k = 1; k <= 4; k++) begin
      chk("t1_re", 64'(vrf_re_o), 64'd1);
      chk("t1_raddr", 64'(vrf_raddr_o), 64'(8 + k - 1));
      chk("t1_valid", 64'(op_valid_o), 64'(k >= 2));
      if (k >= 2) chk("t1_cdata", op_data_o, elem(8 + k - 2));
      chk("t1_ready", 64'(req_ready_o), 64'd0);
      step();
    end
    chk("t1_c5_re", 64'(vrf_re_o), 64'd0);
    chk("t1_c5_valid", 64'(op_valid_o), 64'd1);
    chk("t1_c5_last", 64'(op_last_o), 64'd1);
    chk("t1_c5_data", op_data_o, elem(11));
    chk("t1_c5_busy", 64'(busy_o), 64'd1);
    step();
    chk("t1_c6_ready", 64'(req_ready_o), 64'd1);
    chk("t1_c6_busy", 64'(busy_o), 64'd0);
    chk("t1_c6_valid", 64'(op_valid_o), 64'd0);
    check_stream("t1", 8, 4);

    // vs=0 len=6 with downstream backpressure: only 4 reads until drained
    clear_logs();
    op_ready_i = 1'b0;
    send_req(0, 6);
    for (int k = 0; k < 6; k++) step();
    chk("t2_nrd_full", 64'(rd_addr_q.size()), 64'd4);
    chk("t2_re_off", 64'(vrf_re_o), 64'd0);
    chk("t2_hold_valid", 64'(op_valid_o), 64'd1);
    chk("t2_hold_data", op_data_o, elem(0));
    op_ready_i = 1'b1;
    wait_idle(50);
    check_stream("t2", 0, 6);

    // vs=1 len=3 with read grant withheld on cycles 2-3
    clear_logs();
    send_req(1, 3);
    step();
    vrf_rvalid_i = 1'b0;
    chk("t3_stall_a", 64'(vrf_raddr_o), 64'd5);
    step();
    chk("t3_stall_b", 64'(vrf_raddr_o), 64'd5);
    chk("t3_stall_re", 64'(vrf_re_o), 64'd1);
    step();
    vrf_rvalid_i = 1'b1;
    wait_idle(50);
    check_stream("t3", 4, 3);

    // vs=31 len=6 wraps to v0
    clear_logs();
    send_req(31, 6);
    wait_idle(50);
    check_stream("t4", 124, 6);

    // len=0 is accepted and produces nothing
    clear_logs();
    req_valid_i = 1'b1;
    req_vs_i    = 5'd7;
    req_len_i   = 8'd0;
    chk("t5_ready", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_busy", 64'(busy_o), 64'd0);
      chk("t5_re", 64'(vrf_re_o), 64'd0);
      chk("t5_valid", 64'(op_valid_o), 64'd0);
      step();
    end
    chk("t5_nout", 64'(out_data_q.size()), 64'd0);
    chk("t5_nrd", 64'(rd_addr_q.size()), 64'd0);

    // reset after two pushes discards the buffered elements
    clear_logs();
    op_ready_i = 1'b0;
    send_req(5, 8);
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    op_ready_i = 1'b1;
    chk("t6_valid", 64'(op_valid_o), 64'd0);
    chk("t6_re", 64'(vrf_re_o), 64'd0);
    chk("t6_ready", 64'(req_ready_o), 64'd1);
    chk("t6_busy", 64'(busy_o), 64'd0);
    clear_logs();
    send_req(3, 2);
    wait_idle(50);
    step();
    check_stream("t6", 12, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
